// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multicycle CPU control path: the default phase
// depth, fixed phase indices, sequencer state encoding and the exception
// cause codes used by the CP0 entry logic.
package mc_cpu_pkg;

    // Default depth of the one-hot phase register.
    localparam int MC_MAX_PHASES = 5;

    // Phases with fixed meaning in every instruction.
    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;

    // Exception cause codes written into CP0 Cause.ExcCode.
    typedef enum logic [4:0] {
        EXC_SYSCALL = 5'b01000,
        EXC_BREAK   = 5'b01001,
        EXC_TEQ     = 5'b01101
    } exc_cause_e;

    // Sequencer mode: normal phase stepping, or the single trap-entry cycle.
    typedef enum logic {
        SEQ_RUN  = 1'b0,
        SEQ_TRAP = 1'b1
    } seq_state_e;

    // Instruction length as the sequencer uses it: anything outside
    // [2, max_phases] runs the full depth.
    function automatic int eff_len(input int len, input int max_phases);
        return ((len < 2) || (len > max_phases)) ? max_phases : len;
    endfunction

endpackage

// File: rtl/mc_perf_counter.sv
// Free-running CNT_W-bit event counter with enable; wraps from all-ones to 0.
// Used by mc_phase_sequencer when MC_SEQ_PERF_CNT_EN is defined.
module mc_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count one per enabled cycle; natural overflow provides the wrap.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mc_phase_sequencer.sv
// Timing-phase generator for the multicycle CPU. Produces a one-hot phase
// vector of configurable depth with per-instruction length, early end,
// memory wait states, an MDU start/done handshake and a trap-entry cycle.
// Optional performance counters are built when MC_SEQ_PERF_CNT_EN is defined;
// otherwise retire_cnt and stall_cnt are tied to zero.
module mc_phase_sequencer
    import mc_cpu_pkg::*;
#(
    parameter  int MAX_PHASES = MC_MAX_PHASES,
    parameter  int CNT_W      = 32,
    localparam int PW         = $clog2(MAX_PHASES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PW-1:0]         len,
    input  logic                  early_end,
    input  logic                  mem_wait,
    input  logic                  mdu_req,
    input  logic                  mdu_done,
    input  logic                  exc_req,
    output logic [MAX_PHASES-1:0] phase,
    output logic [PW-1:0]         phase_idx,
    output logic                  fetch,
    output logic                  mdu_start,
    output logic                  stall,
    output logic                  trap,
    output logic                  retire,
    output logic [CNT_W-1:0]      retire_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    seq_state_e            r_state;
    seq_state_e            w_state_nxt;
    logic [MAX_PHASES-1:0] r_phase;
    logic [MAX_PHASES-1:0] w_phase_nxt;
    logic [PW-1:0]         r_idx;
    logic [PW-1:0]         w_idx_nxt;
    logic                  r_mdu_pend;
    logic                  w_mdu_pend_nxt;
    logic [PW-1:0]         w_last_idx;
    logic                  w_stall;
    logic                  w_mdu_start;
    logic                  w_retire;

    // Index of the final phase of the current instruction.
    assign w_last_idx = PW'(eff_len(int'(len), MAX_PHASES) - 1);

    // The trap cycle shows no phase at all; otherwise exactly one bit is set.
    assign w_phase_nxt = (w_state_nxt == SEQ_TRAP) ? '0
                                                   : (MAX_PHASES'(1) << w_idx_nxt);

    // State register: mode, one-hot phase, binary index and MDU pending flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= SEQ_RUN;
            r_phase    <= MAX_PHASES'(1);
            r_idx      <= '0;
            r_mdu_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_idx      <= w_idx_nxt;
            r_mdu_pend <= w_mdu_pend_nxt;
        end
    end

    // Next phase and per-cycle strobes; in phase >= 2 the order is
    // exception, memory wait, MDU wait, end, advance.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_mdu_pend_nxt = r_mdu_pend;
        w_stall        = 1'b0;
        w_mdu_start    = 1'b0;
        w_retire       = 1'b0;

        if (r_state == SEQ_TRAP) begin
            w_state_nxt = SEQ_RUN;
            w_idx_nxt   = PW'(PH_FETCH);
        end else if (r_idx == PW'(PH_FETCH)) begin
            w_idx_nxt = PW'(PH_DECODE);
        end else if (r_idx == PW'(PH_DECODE)) begin
            if (len == PW'(2)) begin
                w_retire  = 1'b1;
                w_idx_nxt = PW'(PH_FETCH);
            end else begin
                w_idx_nxt = PW'(2);
            end
        end else if (exc_req) begin
            w_state_nxt    = SEQ_TRAP;
            w_idx_nxt      = PW'(PH_FETCH);
            w_mdu_pend_nxt = 1'b0;
        end else if (mem_wait) begin
            w_stall = 1'b1;
        end else if (r_mdu_pend && !mdu_done) begin
            w_stall = 1'b1;
        end else if (!r_mdu_pend && mdu_req) begin
            // Start cycle: any mdu_done seen here belongs to an older operation.
            w_mdu_start    = 1'b1;
            w_mdu_pend_nxt = 1'b1;
            w_stall        = 1'b1;
        end else begin
            w_mdu_pend_nxt = 1'b0;
            if ((r_idx == w_last_idx) || early_end) begin
                w_retire  = 1'b1;
                w_idx_nxt = PW'(PH_FETCH);
            end else begin
                w_idx_nxt = r_idx + PW'(1);
            end
        end
    end

    assign phase     = r_phase;
    assign phase_idx = r_idx;
    assign fetch     = r_phase[0];
    assign trap      = (r_state == SEQ_TRAP);
    assign stall     = w_stall;
    assign mdu_start = w_mdu_start;
    assign retire    = w_retire;

`ifdef MC_SEQ_PERF_CNT_EN
    mc_perf_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_retire),
        .o_cnt (retire_cnt)
    );

    mc_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_stall),
        .o_cnt (stall_cnt)
    );
`else
    assign retire_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_mc_phase_sequencer.sv
// Directed bench for mc_phase_sequencer (default depth 5) plus a narrow
// mc_perf_counter instance for the wrap-around check.
module tb_mc_phase_sequencer;

    localparam int MAX_P = 5;
    localparam int CNT_W = 32;
    localparam int PW    = $clog2(MAX_P);
`ifdef MC_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [PW-1:0]    len = '0;
    logic             early_end = 1'b0;
    logic             mem_wait = 1'b0;
    logic             mdu_req = 1'b0;
    logic             mdu_done = 1'b0;
    logic             exc_req = 1'b0;
    logic [MAX_P-1:0] phase;
    logic [PW-1:0]    phase_idx;
    logic             fetch;
    logic             mdu_start;
    logic             stall;
    logic             trap;
    logic             retire;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             cnt_en = 1'b0;
    logic [2:0]       cnt_small;

    int n_total = 0;
    int n_bad   = 0;

    mc_phase_sequencer #(.MAX_PHASES(MAX_P), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .len        (len),
        .early_end  (early_end),
        .mem_wait   (mem_wait),
        .mdu_req    (mdu_req),
        .mdu_done   (mdu_done),
        .exc_req    (exc_req),
        .phase      (phase),
        .phase_idx  (phase_idx),
        .fetch      (fetch),
        .mdu_start  (mdu_start),
        .stall      (stall),
        .trap       (trap),
        .retire     (retire),
        .retire_cnt (retire_cnt),
        .stall_cnt  (stall_cnt)
    );

    mc_perf_counter #(.CNT_W(3)) u_small_cnt (
        .clk   (clk),
        .reset (reset),
        .i_en  (cnt_en),
        .o_cnt (cnt_small)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle, then check the visible phase and the combinational strobes.
    task automatic look(input string tag, input int idx, input bit ret, input bit stl);
        logic [MAX_P-1:0] ph_exp;
        #1;
        ph_exp      = '0;
        ph_exp[idx] = 1'b1;
        check({tag, ".idx"},    32'(phase_idx), 32'(idx));
        check({tag, ".phase"},  32'(phase),     32'(ph_exp));
        check({tag, ".fetch"},  32'(fetch),     32'(idx == 0));
        check({tag, ".retire"}, 32'(retire),    32'(ret));
        check({tag, ".stall"},  32'(stall),     32'(stl));
        check({tag, ".trap"},   32'(trap),      32'd0);
    endtask

    initial begin
        // Reset
        len = 3'd4;
        #2 reset = 1'b0;
        #1;
        check("rst.phase",  32'(phase),     32'd1);
        check("rst.idx",    32'(phase_idx), 32'd0);
        check("rst.trap",   32'(trap),      32'd0);
        check("rst.stall",  32'(stall),     32'd0);
        check("rst.retire", 32'(retire),    32'd0);
        check("rst.start",  32'(mdu_start), 32'd0);
        check("rst.rcnt",   retire_cnt,     32'd0);
        check("rst.scnt",   stall_cnt,      32'd0);
        #9 reset = 1'b1;

        // len = 4, no stalls: 0,1,2,3,0
        look("l4.c0", 0, 0, 0); tick();
        look("l4.c1", 1, 0, 0); tick();
        look("l4.c2", 2, 0, 0); tick();
        look("l4.c3", 3, 1, 0); tick();
        look("l4.c4", 0, 0, 0);
        check("l4.rcnt", retire_cnt, cnt_exp(1));
        check("l4.scnt", stall_cnt,  cnt_exp(0));

        // len = 5, early_end in phase 2: 0,1,2,0
        len = 3'd5;
        tick(); look("ee.c1", 1, 0, 0);
        tick(); early_end = 1'b1; look("ee.c2", 2, 1, 0);
        tick(); early_end = 1'b0; look("ee.c3", 0, 0, 0);

        // len = 5, mem_wait for 3 cycles in phase 3
        tick(); look("mw.p1", 1, 0, 0);
        tick(); look("mw.p2", 2, 0, 0);
        tick(); mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look($sformatf("mw.h%0d", i), 3, 0, 1);
            tick();
        end
        mem_wait = 1'b0;
        look("mw.rel", 3, 0, 0); tick();
        look("mw.p4", 4, 1, 0); tick();
        look("mw.p0", 0, 0, 0);
        check("mw.scnt", stall_cnt,  cnt_exp(3));
        check("mw.rcnt", retire_cnt, cnt_exp(3));

        // len = 4, MDU op in phase 2, done 7 cycles after start
        len = 3'd4;
        tick(); look("md.p1", 1, 0, 0);
        tick(); mdu_req = 1'b1; mdu_done = 1'b1;
        look("md.s0", 2, 0, 1);
        check("md.start0", 32'(mdu_start), 32'd1);
        tick(); mdu_done = 1'b0;
        for (int i = 1; i < 7; i++) begin
            look($sformatf("md.w%0d", i), 2, 0, 1);
            check($sformatf("md.start%0d", i), 32'(mdu_start), 32'd0);
            tick();
        end
        mdu_done = 1'b1;
        look("md.done", 2, 0, 0);
        check("md.start7", 32'(mdu_start), 32'd0);
        tick(); mdu_req = 1'b0; mdu_done = 1'b0;
        look("md.p3", 3, 1, 0); tick();
        look("md.p0", 0, 0, 0);
        check("md.scnt", stall_cnt,  cnt_exp(10));
        check("md.rcnt", retire_cnt, cnt_exp(4));

        // len = 5, exception in phase 3 while MDU pending
        len = 3'd5;
        tick(); look("ex.p1", 1, 0, 0);
        tick(); look("ex.p2", 2, 0, 0);
        tick(); mdu_req = 1'b1;
        look("ex.s", 3, 0, 1);
        check("ex.start", 32'(mdu_start), 32'd1);
        tick(); exc_req = 1'b1;
        look("ex.req", 3, 0, 0);
        tick(); exc_req = 1'b0; mdu_req = 1'b0;
        #1;
        check("ex.trap",   32'(trap),      32'd1);
        check("ex.phase",  32'(phase),     32'd0);
        check("ex.idx",    32'(phase_idx), 32'd0);
        check("ex.stall",  32'(stall),     32'd0);
        check("ex.retire", 32'(retire),    32'd0);
        tick(); look("ex.p0", 0, 0, 0);
        check("ex.rcnt", retire_cnt, cnt_exp(4));

        // len = 3: a fresh MDU request starts again, so the pending flag was cleared
        len = 3'd3;
        tick(); look("pc.p1", 1, 0, 0);
        tick(); mdu_req = 1'b1;
        look("pc.s", 2, 0, 1);
        check("pc.start", 32'(mdu_start), 32'd1);
        tick(); mdu_done = 1'b1;
        look("pc.done", 2, 1, 0);
        tick(); mdu_req = 1'b0; mdu_done = 1'b0;
        look("pc.p0", 0, 0, 0);

        // len = 2 ends in decode
        len = 3'd2;
        tick(); look("l2.p1", 1, 1, 0);
        tick(); look("l2.p0", 0, 0, 0);

        // len = 0 runs the full depth of 5
        len = 3'd0;
        tick(); look("l0.p1", 1, 0, 0);
        tick(); look("l0.p2", 2, 0, 0);
        tick(); look("l0.p3", 3, 0, 0);
        tick(); look("l0.p4", 4, 1, 0);
        tick(); look("l0.p0", 0, 0, 0);
        check("l0.rcnt", retire_cnt, cnt_exp(7));
        check("l0.scnt", stall_cnt,  cnt_exp(12));

        // Asynchronous reset in the middle of phase 3
        len = 3'd5;
        tick(); tick(); tick(); mem_wait = 1'b1;
        look("ar.p3", 3, 0, 1);
        #2 reset = 1'b0;
        #1;
        check("ar.phase",  32'(phase),     32'd1);
        check("ar.idx",    32'(phase_idx), 32'd0);
        check("ar.stall",  32'(stall),     32'd0);
        check("ar.retire", 32'(retire),    32'd0);
        check("ar.trap",   32'(trap),      32'd0);
        check("ar.rcnt",   retire_cnt,     32'd0);
        check("ar.scnt",   stall_cnt,      32'd0);
        mem_wait = 1'b0;
        #2 reset = 1'b1;
        look("ar.c0", 0, 0, 0);
        tick(); look("ar.c1", 1, 0, 0);
        tick(); look("ar.c2", 2, 0, 0);

        // 3-bit counter: seven counts reach all-ones, the eighth wraps to 0
        cnt_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("wrap.ones", 32'(cnt_small), 32'd7);
        tick();
        check("wrap.zero", 32'(cnt_small), 32'd0);
        cnt_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_phase_sequencer.md
Name: mc_phase_sequencer

Overview:
- Parametrised timing-phase generator for the multicycle, non-pipelined CPU.
- Replaces the fixed five-state one-hot T-counter with a configurable-depth one-hot phase register.
- Supports per-instruction phase length, early termination, memory wait states, a multi-cycle MDU start/done handshake, and a dedicated trap cycle.
- Sits between the instruction decoder, which supplies length and condition inputs, and the control-signal decode logic, which consumes the phase vector.

Parameters:
- MAX_PHASES, 5, number of phases (one-hot width); legal range 3..16.
- CNT_W, 32, width of the performance counters.
- PW is a localparam, not a parameter: $clog2(MAX_PHASES), the width of phase indices.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- len  in  PW  total phases of the current instruction; combinational from the decoder; valid from phase 1 onward.
- early_end  in  1  end the instruction after the current phase (e.g. branch not taken); honoured in phase >= 2.
- mem_wait  in  1  memory not ready; hold the current phase.
- mdu_req  in  1  current phase issues an MDU operation.
- mdu_done  in  1  MDU result ready.
- exc_req  in  1  exception request (syscall/break/teq/overflow); honoured in phase >= 2.
- phase  out  MAX_PHASES  one-hot current phase; all zeros during trap.
- phase_idx  out  PW  binary index of the current phase.
- fetch  out  1  equals phase[0].
- mdu_start  out  1  single-cycle MDU start pulse.
- stall  out  1  current phase held this cycle.
- trap  out  1  trap cycle active (CP0 exception entry).
- retire  out  1  one-cycle pulse when an instruction completes normally.
- retire_cnt  out  CNT_W  count of retired instructions.
- stall_cnt  out  CNT_W  count of stall cycles.

Behaviour:
- Reset (asynchronous, active-low) values: phase = 1 (phase 0), phase_idx = 0, trap = 0, mdu_start = 0, stall = 0, retire = 0, both counters = 0, internal mdu_pend = 0.
- Phase 0 (fetch) always advances to phase 1. Phase 1 (decode) always advances to phase 2 unless len == 2, which ends the instruction.
- Effective length: len values outside [2, MAX_PHASES] are treated as MAX_PHASES.
- Priority each cycle in phase >= 2, highest first:
  1. exc_req
  2. mem_wait
  3. MDU wait
  4. end (idx == efflen-1 or early_end)
  5. advance to idx+1
- exc_req: next cycle is trap (phase = 0, trap = 1, phase_idx = 0). mdu_pend is cleared. No retire. The cycle after trap is phase 0.
- mem_wait: hold the phase; stall = 1.
- MDU handshake:
  - First cycle of a phase with mdu_req = 1 and mdu_pend = 0: mdu_start = 1, mdu_pend set, hold, stall = 1.
  - While mdu_pend = 1: hold until mdu_done = 1. On mdu_done, clear mdu_pend and apply end/advance in that same cycle.
  - mdu_done in the mdu_start cycle is ignored.
- End: next phase is 0; retire = 1 in the cycle the final phase is left. A held final phase does not retire until released.
- Phase 0/1 ignore exc_req, mem_wait, mdu_req, and early_end.
- phase and phase_idx are registered outputs. stall, mdu_start, and retire are combinational from state and inputs.
- Counters wrap to 0 past all-ones.
- Trap cycle: stall = 0; not counted as a stall.

Optional Feature:
- Macro MC_SEQ_PERF_CNT_EN.
- Defined: retire_cnt increments on every retire; stall_cnt increments on every stall cycle.
- Undefined: no counter registers exist; retire_cnt and stall_cnt are driven constant 0.

Decomposition:
- Shared package mc_cpu_pkg holds:
  - MC_MAX_PHASES default
  - phase index constants PH_FETCH = 0, PH_DECODE = 1
  - exception cause codes (SYSCALL 5'b01000, BREAK 5'b01001, TEQ 5'b01101) used by the downstream CP0 logic
- Optional sub-module mc_perf_counter: a CNT_W wrapping counter with enable, instantiated twice under the macro.

Test Plan:
- Reset, then len = 4 with no stalls: phase_idx sequence is 0,1,2,3,0; retire pulses once as phase 3 is left; retire_cnt = 1.
- len = 5 with early_end asserted at phase 2: phase_idx sequence is 0,1,2,0; retire = 1 at the phase 2 exit.
- mem_wait held for 3 cycles at phase 3 of len = 5: phase 3 lasts 4 cycles; stall_cnt = 3; then phase 4, then phase 0.
- mdu_req at phase 2 with mdu_done 7 cycles after mdu_start: a single mdu_start pulse; phase 2 lasts 8 cycles; a mdu_done driven in the start cycle is ignored.
- exc_req at phase 3 while mdu_pend = 1: next cycle trap = 1 with phase all zeros; then phase 0; no retire; mdu_pend cleared.
- Reset asserted asynchronously mid-phase 3, then released: outputs return immediately to reset values; counters = 0; sequencing restarts at phase 0. Also check len = 0 behaves as MAX_PHASES, and that a counter preloaded at all-ones wraps to 0.
